// File: rtl/jt51_sepn.sv
// rtl/jt51_sepn.sv - slot demultiplexer for time-multiplexed pipelines (optional macro JT51_SEPN_CHG_EN)
module jt51_sepn #(
    parameter int WIDTH = 10,
    parameter int SLOTS = 32,
    parameter int STG   = 0,
    parameter int CW    = $clog2(SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   zero,
    input  logic [WIDTH-1:0]       mixed,
    input  logic                   freeze,
    input  logic [CW-1:0]          rd_idx,
    output logic [WIDTH-1:0]       rd_data,
    output logic [SLOTS*WIDTH-1:0] slots_flat,
    output logic                   locked,
    output logic                   frozen,
    output logic                   frame_done,
    output logic                   sync_err,
    output logic [SLOTS-1:0]       chg
);

    // Slot offset folded into a constant so idx needs a single conditional subtract.
    localparam int OFF = (STG == 0) ? 0 : SLOTS - STG;

    logic [CW-1:0]                  cnt_q;
    logic [CW-1:0]                  phase;
    logic [CW-1:0]                  cnt_nx;
    logic [CW:0]                    sum;
    logic [CW-1:0]                  idx;
    logic                           cap;
    logic                           boundary;
    logic [SLOTS-1:0][WIDTH-1:0]    bank;

    assign phase    = zero ? '0 : cnt_q;
    assign cnt_nx   = (phase == CW'(SLOTS - 1)) ? '0 : phase + CW'(1);
    assign sum      = {1'b0, phase} + (CW+1)'(OFF + 1);
    assign idx      = (sum >= (CW+1)'(SLOTS)) ? CW'(sum - (CW+1)'(SLOTS)) : CW'(sum);
    assign cap      = cen & locked & ~frozen;
    assign boundary = cen & locked & (idx == CW'(SLOTS - 1));
    assign slots_flat = bank;

    // Phase tracking, lock, freeze hand-off at frame boundaries and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            locked     <= 1'b0;
            frozen     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (cen) begin
                cnt_q <= cnt_nx;
                if (zero) begin
                    locked <= 1'b1;
                end
                if (zero && locked && (cnt_q != '0)) begin
                    sync_err <= 1'b1;
                end
                if (boundary) begin
                    frozen     <= freeze;
                    frame_done <= ~frozen;
                end
            end
        end
    end

    // Per-slot capture of the pipelined sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (cap) begin
            bank[idx] <= mixed;
        end
    end

    // Indexed read port, free-running; out-of-range indices read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= (int'(rd_idx) < SLOTS) ? bank[rd_idx] : '0;
        end
    end

`ifdef JT51_SEPN_CHG_EN
    logic [SLOTS-1:0] chg_nx;

    // Sticky change flags; a frame_done cycle restarts them, keeping that cycle's own compare.
    always_comb begin
        chg_nx = frame_done ? '0 : chg;
        if (cap) begin
            chg_nx[idx] = (mixed != bank[idx]) | chg_nx[idx];
        end
    end

    // Change-flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= '0;
        end else begin
            chg <= chg_nx;
        end
    end
`else
    assign chg = '0;
`endif

endmodule

// File: tb/tb_jt51_sepn.sv
// tb/tb_jt51_sepn.sv - directed self-checking bench for jt51_sepn
module tb_jt51_sepn;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cen;
    logic         zero;
    logic [9:0]   mixed;
    logic         freeze;
    logic [4:0]   rd_idx;
    logic         zero24;
    logic [9:0]   mixed24;
    logic         freeze24;

    logic [9:0]   rd32, rd5, rd24;
    logic [319:0] flat32, flat5;
    logic [239:0] flat24;
    logic         lk32, fz32, fd32, se32;
    logic         lk5, fz5, fd5, se5;
    logic         lk24, fz24, fd24, se24;
    logic [31:0]  chg32, chg5;
    logic [23:0]  chg24;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int se24_cnt = 0;
    logic [319:0] exp32;
    logic [239:0] exp24;

    always #5 clk = ~clk;

    jt51_sepn #(.WIDTH(10), .SLOTS(32), .STG(0)) u32 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .mixed(mixed),
        .freeze(freeze), .rd_idx(rd_idx), .rd_data(rd32), .slots_flat(flat32),
        .locked(lk32), .frozen(fz32), .frame_done(fd32), .sync_err(se32), .chg(chg32)
    );

    jt51_sepn #(.WIDTH(10), .SLOTS(32), .STG(5)) u5 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .mixed(mixed),
        .freeze(freeze), .rd_idx(rd_idx), .rd_data(rd5), .slots_flat(flat5),
        .locked(lk5), .frozen(fz5), .frame_done(fd5), .sync_err(se5), .chg(chg5)
    );

    jt51_sepn #(.WIDTH(10), .SLOTS(24), .STG(0)) u24 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero24), .mixed(mixed24),
        .freeze(freeze24), .rd_idx(rd_idx), .rd_data(rd24), .slots_flat(flat24),
        .locked(lk24), .frozen(fz24), .frame_done(fd24), .sync_err(se24), .chg(chg24)
    );

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic z, input logic [9:0] m);
        zero  = z;
        mixed = m;
        @(posedge clk);
        #1;
        fd_cnt += int'(fd32);
        se_cnt += int'(se32);
    endtask

    task automatic tick24(input logic z, input logic [9:0] m);
        zero24  = z;
        mixed24 = m;
        zero    = 1'b0;
        @(posedge clk);
        #1;
        se24_cnt += int'(se24);
    endtask

    task automatic frame32(input int base);
        for (int p = 0; p < 32; p++) begin
            tick(p == 0, 10'(p + base));
        end
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; zero = 1'b0; mixed = '0; freeze = 1'b0;
        rd_idx = '0; zero24 = 1'b0; mixed24 = '0; freeze24 = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        check("reset_slots", flat32, '0);
        check("reset_rd", rd32, '0);
        check("reset_flags", {lk32, fz32, fd32, se32}, 4'b0);
        check("reset_chg", chg32, '0);

        rst_n = 1'b1;
        cen   = 1'b1;
        frame32(0);
        frame32(0);
        for (int k = 0; k < 32; k++) exp32[k*10 +: 10] = 10'((k + 31) % 32);
        check("slots_stg0", flat32, exp32);
        check("locked", lk32, 1'b1);
        for (int k = 0; k < 32; k++) exp32[k*10 +: 10] = 10'((k + 4) % 32);
        check("slots_stg5", flat5, exp32);
        fd_cnt = 0;
        frame32(0);
        check("frame_done_once", fd_cnt, 1);
        check("no_sync_err", se_cnt, 0);

        cen = 1'b0;
        rd_idx = 5'd3;
        tick(1'b0, 10'd999);
        check("rd_stg5_idx3", rd5, 10'd7);
        check("rd_stg0_idx3", rd32, 10'd2);
        cen = 1'b1;

        for (int p = 0; p < 32; p++) begin
            freeze = (p >= 12);
            tick(p == 0, 10'(p + 64));
            if (p == 30) begin
                check("frz_frame_done", fd32, 1'b1);
                check("frz_frozen", fz32, 1'b1);
                check("frz_slot31", flat32[31*10 +: 10], 10'd94);
            end
        end
        check("frz_slot0_held", flat32[9:0], 10'd31);
        exp32[9:0] = 10'd31;
        for (int k = 1; k < 32; k++) exp32[k*10 +: 10] = 10'(k + 63);

        fd_cnt = 0;
        for (int p = 0; p < 32; p++) begin
            freeze = (p < 5);
            tick(p == 0, 10'(p + 200));
            if (p == 30) begin
                check("frz_snapshot", flat32, exp32);
                check("frz_no_done", fd_cnt, 0);
                check("frz_released", fz32, 1'b0);
            end
        end
        check("release_slot0", flat32[9:0], 10'd231);
        check("release_slot1", flat32[19:10], 10'd64);
        exp32[9:0] = 10'd231;

        cen = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 10'(i + 700));
        check("cen0_hold", flat32, exp32);
        check("cen0_pulses", {fd32, se32}, 2'b0);
        cen = 1'b1;

`ifndef JT51_SEPN_CHG_EN
        check("chg_tied", chg32, '0);
`endif

        for (int p = 0; p < 10; p++) tick(p == 0, 10'(p + 400));
        rst_n = 1'b0;
        #1;
        check("midrst_slots", flat32, '0);
        check("midrst_flags", {lk32, fz32, fd32, se32, rd32}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick(1'b0, 10'(i + 500));
        check("nolock_slots", flat32, '0);
        check("nolock_locked", lk32, 1'b0);
        tick(1'b1, 10'd7);
        tick(1'b0, 10'd8);
        check("relock_slot1", flat32[19:10], 10'd0);
        check("relock_slot2", flat32[29:20], 10'd8);

        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 24; p++) tick24(p == 0, 10'(p));
        for (int p = 0; p < 10; p++) tick24(p == 0, 10'(p));
        check("s24_no_err_yet", se24_cnt, 0);
        tick24(1'b1, 10'd77);
        check("s24_sync_err", se24, 1'b1);
        check("s24_slot1", flat24[19:10], 10'd77);
        tick24(1'b0, 10'd1);
        check("s24_err_pulse", se24, 1'b0);
        for (int p = 2; p < 24; p++) tick24(1'b0, 10'(p));
        check("s24_slot0", flat24[9:0], 10'd23);
        for (int p = 0; p < 24; p++) tick24(p == 0, 10'(p));
        for (int k = 0; k < 24; k++) exp24[k*10 +: 10] = 10'((k + 23) % 24);
        check("s24_slots", flat24, exp24);
        check("s24_err_total", se24_cnt, 1);
        rd_idx = 5'd30;
        tick24(1'b0, 10'd0);
        check("s24_rd_oob", rd24, 10'd0);
        rd_idx = 5'd5;
        tick24(1'b0, 10'd1);
        check("s24_rd5", rd24, 10'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
